// File: rtl/vga_render_pipe.sv
// Lava-runner pixel renderer: region compares, priority colour select and
// frame-counted tint fade in a 3-stage pipeline advanced by the pixel strobe.
module vga_render_pipe #(
  parameter int COLOR_W    = 8,
  parameter int NUM_RECT   = 16,
  parameter int TINT_SHIFT = 4,
  parameter int LAVA_Y     = 380,
  parameter int CEIL_Y     = 75,
  parameter int SPRITE_SZ  = 16,
  localparam int AW = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               active_pixels,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  input  logic [9:0]         lava_wall_x,
  input  logic [9:0]         lava_height,
  input  logic [2:0]         game_state,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [40:0]        cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_busy,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N
);

  localparam logic [9:0] COL_X0   = 10'd270;
  localparam logic [9:0] COL_X1   = 10'd309;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] GOAL_X0  = 10'd580;
  localparam logic [9:0] GOAL_X1  = 10'd630;
  localparam logic [9:0] GOAL_Y0  = 10'd355;
  localparam logic [9:0] GOAL_Y1  = 10'd360;
  localparam logic [TINT_SHIFT:0] TINT_MAX = {1'b1, {TINT_SHIFT{1'b0}}};
  localparam logic [TINT_SHIFT:0] TINT_ONE = (TINT_SHIFT + 1)'(1);

  typedef enum logic [1:0] {TS_NONE = 2'd0, TS_OVER = 2'd1, TS_WIN = 2'd2} tint_state_t;

  // Top COLOR_W bits of an 8-bit channel (zero-padded when COLOR_W > 8).
  function automatic logic [COLOR_W-1:0] f_sc(input logic [7:0] c);
    logic [COLOR_W+7:0] t;
    t = {c, {COLOR_W{1'b0}}};
    return t[COLOR_W+7 -: COLOR_W];
  endfunction

  function automatic logic f_sprite(input logic [10:0] px, input logic [10:0] py);
    logic hit;
    hit = 1'b0;
    if (px >= 11'd5 && px <= 11'd10 && py <= 11'd5) hit = 1'b1;
    if (px >= 11'd7 && px <= 11'd8 && py >= 11'd6 && py <= 11'd12) hit = 1'b1;
    if (py >= 11'd8 && py <= 11'd12 && (px == 11'd15 - py || px == py)) hit = 1'b1;
    if (py >= 11'd13 && py <= 11'd15 && (px == 11'd20 - py || px == py - 11'd5)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [COLOR_W-1:0] f_blend(input logic [COLOR_W-1:0] base,
                                                 input logic [COLOR_W-1:0] tgt,
                                                 input logic [TINT_SHIFT:0] lvl);
    logic signed [COLOR_W:0]              diff;
    logic signed [TINT_SHIFT+1:0]         lvl_s;
    logic signed [COLOR_W+TINT_SHIFT+2:0] prod;
    diff  = $signed({1'b0, tgt}) - $signed({1'b0, base});
    lvl_s = $signed({1'b0, lvl});
    prod  = diff * lvl_s;
    return base + COLOR_W'(prod >>> TINT_SHIFT);
  endfunction

  logic w_frame_start;
  assign w_frame_start = pix_valid && (x == 10'd0) && (y == 10'd0);

  // Rectangle tables: shadow written by config, active swapped in at frame start.
  logic [40:0] r_shadow [NUM_RECT];
  logic [40:0] r_active [NUM_RECT];
  logic        r_busy;
  logic        w_swap;
  assign w_swap   = w_frame_start && r_busy;
  assign cfg_busy = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        if (w_swap) r_active[i] <= r_shadow[i];
        if (cfg_we && cfg_addr == AW'(i)) r_shadow[i] <= cfg_data;
      end
      if (cfg_commit) r_busy <= 1'b1;
      else if (w_swap) r_busy <= 1'b0;
    end
  end

  logic [NUM_RECT-1:0] w_rect_hit;
  generate
    for (genvar gi = 0; gi < NUM_RECT; gi++) begin : g_rect
      assign w_rect_hit[gi] = r_active[gi][40] &&
                              x >= r_active[gi][39:30] && x <= r_active[gi][29:20] &&
                              y >= r_active[gi][19:10] && y <= r_active[gi][9:0];
    end
  endgenerate

  logic [9:0]  w_col_top;
  logic [10:0] w_wall_end, w_dx, w_dy;
  logic        w_ceil, w_floor, w_col, w_goal, w_wall, w_player;
  assign w_col_top  = SCREEN_H - lava_height;
  assign w_wall_end = {1'b0, lava_wall_x} + 11'd10;
  assign w_dx       = {1'b0, x} - {1'b0, player_x};
  assign w_dy       = {1'b0, y} - {1'b0, player_y};
  assign w_ceil     = y < 10'(CEIL_Y);
  assign w_floor    = y >= 10'(LAVA_Y);
  assign w_col      = x >= COL_X0 && x <= COL_X1 && (lava_height >= SCREEN_H || y >= w_col_top);
  assign w_goal     = x >= GOAL_X0 && x <= GOAL_X1 && y >= GOAL_Y0 && y <= GOAL_Y1;
  assign w_wall     = x >= lava_wall_x && {1'b0, x} < w_wall_end;
  // Negative offsets wrap to large values, so the box test rejects them too.
  assign w_player   = w_dx < 11'(SPRITE_SZ) && w_dy < 11'(SPRITE_SZ) && f_sprite(w_dx, w_dy);

  // Stage 1: region flags.
  logic r_s1_ceil, r_s1_floor, r_s1_col, r_s1_rect, r_s1_goal, r_s1_wall, r_s1_player;
  logic r_s1_act, r_s1_hs, r_s1_vs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_s1_ceil, r_s1_floor, r_s1_col, r_s1_rect, r_s1_goal, r_s1_wall, r_s1_player} <= '0;
      r_s1_act <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
    end else if (pix_valid) begin
      r_s1_ceil   <= w_ceil;
      r_s1_floor  <= w_floor;
      r_s1_col    <= w_col;
      r_s1_rect   <= |w_rect_hit;
      r_s1_goal   <= w_goal;
      r_s1_wall   <= w_wall;
      r_s1_player <= w_player;
      r_s1_act    <= active_pixels;
      r_s1_hs     <= hs_in;
      r_s1_vs     <= vs_in;
    end
  end

  // Stage 2: priority select, later assignments win.
  logic [23:0] w_base24;
  always_comb begin
    w_base24 = 24'hC0C0C0;
    if (r_s1_ceil)   w_base24 = 24'h505050;
    if (r_s1_floor)  w_base24 = 24'hFF4500;
    if (r_s1_col)    w_base24 = 24'hFF4500;
    if (r_s1_rect)   w_base24 = 24'h505050;
    if (r_s1_goal)   w_base24 = 24'hFFD700;
    if (r_s1_wall)   w_base24 = 24'hFF6600;
    if (r_s1_player) w_base24 = 24'h0000FF;
  end

  logic [COLOR_W-1:0] r_s2_r, r_s2_g, r_s2_b;
  logic               r_s2_act, r_s2_hs, r_s2_vs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_r   <= '0;
      r_s2_g   <= '0;
      r_s2_b   <= '0;
      r_s2_act <= 1'b0;
      r_s2_hs  <= 1'b1;
      r_s2_vs  <= 1'b1;
    end else if (pix_valid) begin
      r_s2_r   <= f_sc(w_base24[23:16]);
      r_s2_g   <= f_sc(w_base24[15:8]);
      r_s2_b   <= f_sc(w_base24[7:0]);
      r_s2_act <= r_s1_act;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
    end
  end

  // Tint fade state, stepped once per frame start.
  tint_state_t           r_tint_state, w_tint_state_next;
  logic [TINT_SHIFT:0]   r_tint_level, w_tint_level_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tint_state <= TS_NONE;
      r_tint_level <= '0;
    end else begin
      r_tint_state <= w_tint_state_next;
      r_tint_level <= w_tint_level_next;
    end
  end

  always_comb begin
    w_tint_state_next = r_tint_state;
    w_tint_level_next = r_tint_level;
    if (w_frame_start) begin
      if (game_state == 3'd1 || game_state == 3'd2) begin
        w_tint_state_next = (game_state == 3'd1) ? TS_OVER : TS_WIN;
        if (r_tint_state != TS_NONE && r_tint_state != w_tint_state_next)
          w_tint_level_next = TINT_ONE;
        else if (r_tint_level != TINT_MAX)
          w_tint_level_next = r_tint_level + TINT_ONE;
      end else begin
        w_tint_state_next = TS_NONE;
        w_tint_level_next = '0;
      end
    end
  end

  logic [COLOR_W-1:0] w_tgt_g;
  assign w_tgt_g = (r_tint_state == TS_WIN) ? f_sc(8'hD7) : '0;

  // Stage 3: blend and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_valid) begin
      VGA_HS      <= r_s2_hs;
      VGA_VS      <= r_s2_vs;
      VGA_BLANK_N <= r_s2_act;
      if (!r_s2_act) begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end else if (r_tint_state == TS_NONE) begin
        VGA_R <= r_s2_r;
        VGA_G <= r_s2_g;
        VGA_B <= r_s2_b;
      end else begin
        VGA_R <= f_blend(r_s2_r, f_sc(8'hFF), r_tint_level);
        VGA_G <= f_blend(r_s2_g, w_tgt_g, r_tint_level);
        VGA_B <= f_blend(r_s2_b, '0, r_tint_level);
      end
    end
  end

endmodule

// File: tb/tb_vga_render_pipe.sv
// Directed bench for vga_render_pipe: a model predicts each pixel's base colour
// into a queue, popped and blended when the pixel leaves the 3-stage pipe.
module tb_vga_render_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [9:0]  x, y;
  logic        active_pixels, hs_in, vs_in;
  logic [9:0]  player_x, player_y, lava_wall_x, lava_height;
  logic [2:0]  game_state;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [40:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;

  always #5 clk = ~clk;

  vga_render_pipe dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y),
    .active_pixels(active_pixels), .hs_in(hs_in), .vs_in(vs_in),
    .player_x(player_x), .player_y(player_y), .lava_wall_x(lava_wall_x),
    .lava_height(lava_height), .game_state(game_state), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  typedef struct packed {
    logic [23:0] base;
    logic        act;
    logic        hs;
    logic        vs;
  } pix_t;

  pix_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [40:0] m_shadow [16];
  logic [40:0] m_active [16];
  logic        m_busy;
  int          m_level, m_sel;
  logic [26:0] last_exp;
  bit          sprite_bm [16][16];

  localparam logic [26:0] RESET_VEC = {24'h000000, 1'b1, 1'b1, 1'b0};

  wire [26:0] dut_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
  wire [23:0] dut_rgb = {VGA_R, VGA_G, VGA_B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_base(input int px, input int py);
    logic [23:0] c;
    int dx, dy;
    c = 24'hC0C0C0;
    if (py < 75) c = 24'h505050;
    if (py >= 380) c = 24'hFF4500;
    if (px >= 270 && px <= 309 && py >= 480 - int'(lava_height)) c = 24'hFF4500;
    for (int i = 0; i < 16; i++)
      if (m_active[i][40] && px >= int'(m_active[i][39:30]) && px <= int'(m_active[i][29:20]) &&
          py >= int'(m_active[i][19:10]) && py <= int'(m_active[i][9:0]))
        c = 24'h505050;
    if (px >= 580 && px <= 630 && py >= 355 && py <= 360) c = 24'hFFD700;
    if (px >= int'(lava_wall_x) && px < int'(lava_wall_x) + 10) c = 24'hFF6600;
    dx = px - int'(player_x);
    dy = py - int'(player_y);
    if (dx >= 0 && dx < 16 && dy >= 0 && dy < 16 && sprite_bm[dy][dx]) c = 24'h0000FF;
    return c;
  endfunction

  function automatic logic [7:0] blend_ch(input logic [7:0] b, input logic [7:0] t, input int lvl);
    int d;
    d = int'(t) - int'(b);
    return 8'(int'(b) + ((d * lvl) >>> 4));
  endfunction

  function automatic logic [26:0] model_out(input pix_t p, input int lvl, input int sel);
    logic [23:0] rgb, tgt;
    rgb = p.base;
    tgt = (sel == 2) ? 24'hFFD700 : 24'hFF0000;
    if (!p.act) rgb = 24'h0;
    else if (sel != 0)
      rgb = {blend_ch(p.base[23:16], tgt[23:16], lvl), blend_ch(p.base[15:8], tgt[15:8], lvl),
             blend_ch(p.base[7:0], tgt[7:0], lvl)};
    return {rgb, p.hs, p.vs, p.act};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    q.delete();
    m_busy   = 1'b0;
    m_level  = 0;
    m_sel    = 0;
    last_exp = RESET_VEC;
  endtask

  // One pixel strobe: predict, update frame-start state, clock, compare.
  task automatic strobe(input int px, input int py, input logic act, input logic hs, input logic vs);
    pix_t        p;
    int          lvl_s, sel_s;
    logic        fs, swap;
    logic [26:0] e;
    x = 10'(px); y = 10'(py);
    active_pixels = act; hs_in = hs; vs_in = vs;
    pix_valid = 1'b1;
    p.base = model_base(px, py);
    p.act = act; p.hs = hs; p.vs = vs;
    q.push_back(p);
    lvl_s = m_level;
    sel_s = m_sel;
    fs    = (px == 0 && py == 0);
    swap  = fs && m_busy;
    if (fs) begin
      if (game_state == 3'd1 || game_state == 3'd2) begin
        if (m_sel != 0 && m_sel != int'(game_state)) m_level = 1;
        else if (m_level < 16) m_level++;
        m_sel = int'(game_state);
      end else begin
        m_level = 0;
        m_sel   = 0;
      end
    end
    if (swap) m_active = m_shadow;
    if (cfg_commit) m_busy = 1'b1;
    else if (swap) m_busy = 1'b0;
    if (cfg_we) m_shadow[cfg_addr] = cfg_data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    if (q.size() == 3) begin
      p = q.pop_front();
      e = model_out(p, lvl_s, sel_s);
    end else begin
      e = RESET_VEC;
    end
    check("pix", dut_vec, e);
    last_exp = e;
    check("busy", cfg_busy, m_busy);
    $display("strobe x=%0d y=%0d act=%0b -> out=%h busy=%0b", px, py, act, dut_vec, cfg_busy);
  endtask

  task automatic px_at(input int px, input int py);
    strobe(px, py, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("hold", dut_vec, last_exp);
      $display("idle -> out=%h", dut_vec);
    end
  endtask

  int tx[12] = '{100, 100, 100, 100, 280, 280, 269, 310, 580, 630, 631, 605};
  int ty[12] = '{74, 75, 379, 380, 280, 279, 300, 300, 355, 360, 355, 361};

  initial begin
    for (int r = 0; r < 6; r++) for (int c = 5; c <= 10; c++) sprite_bm[r][c] = 1'b1;
    for (int r = 6; r <= 12; r++) begin sprite_bm[r][7] = 1'b1; sprite_bm[r][8] = 1'b1; end
    for (int r = 8; r <= 12; r++) begin sprite_bm[r][7-(r-8)] = 1'b1; sprite_bm[r][8+(r-8)] = 1'b1; end
    for (int r = 13; r <= 15; r++) begin sprite_bm[r][7-(r-13)] = 1'b1; sprite_bm[r][8+(r-13)] = 1'b1; end

    rst_n = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
    active_pixels = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    player_x = 10'd900; player_y = 10'd900; lava_wall_x = 10'd1000; lava_height = 10'd0;
    game_state = 3'd0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", dut_vec, RESET_VEC);
    check("reset_busy", cfg_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pipeline fill at frame start: reset values for two strobes, then ceiling.
    repeat (3) px_at(0, 0);
    check("fill_ceiling", dut_rgb, 24'h505050);

    // Latency with a 2-cycle strobe gap.
    px_at(100, 200);
    px_at(101, 200);
    idle(2);
    px_at(102, 200);
    px_at(103, 200);

    // Region boundaries with a rising column of 200 rows.
    lava_height = 10'd200;
    for (int i = 0; i < 12; i++) px_at(tx[i], ty[i]);
    lava_height = 10'd500;
    px_at(280, 100);
    px_at(269, 100);
    lava_height = 10'd0;

    // Lava wall near the right edge must not wrap to x < 10.
    lava_wall_x = 10'd1015;
    px_at(5, 200);
    px_at(1014, 200);
    px_at(1020, 200);
    px_at(1023, 200);
    lava_wall_x = 10'd1000;

    // Blanking and sync delay.
    strobe(700, 200, 1'b0, 1'b0, 1'b1);
    strobe(701, 200, 1'b1, 1'b1, 1'b0);
    strobe(702, 200, 1'b0, 1'b1, 1'b1);

    // Mid-frame commit: slot 3 only appears after the next frame start.
    px_at(0, 0);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = {1'b1, 10'd100, 10'd200, 10'd300, 10'd310};
    px_at(10, 100);
    cfg_commit = 1'b1;
    px_at(150, 305);
    px_at(150, 305);
    px_at(200, 310);
    px_at(0, 0);
    px_at(150, 305);
    px_at(200, 310);
    px_at(201, 310);
    px_at(100, 300);

    // Commit coincident with frame start defers the swap one frame.
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = {1'b1, 10'd400, 10'd450, 10'd100, 10'd150};
    px_at(10, 100);
    cfg_commit = 1'b1;
    px_at(0, 0);
    px_at(420, 120);
    px_at(420, 120);
    px_at(0, 0);
    px_at(420, 120);
    px_at(450, 150);

    // Player sprite above rectangle.
    player_x = 10'd150; player_y = 10'd300;
    px_at(157, 309);
    px_at(150, 300);
    px_at(155, 310);
    px_at(156, 314);
    px_at(157, 314);
    px_at(165, 300);
    player_x = 10'd900; player_y = 10'd900;
    px_at(500, 200);
    px_at(500, 200);

    // Fade toward game-over red.
    game_state = 3'd1;
    px_at(0, 0);
    repeat (3) px_at(100, 200);
    check("fade_f1", dut_rgb, 24'hC3B4B4);
    repeat (15) begin
      px_at(0, 0);
      px_at(100, 200);
      px_at(100, 200);
    end
    check("fade_f16", dut_rgb, 24'hFF0000);
    px_at(0, 0);
    repeat (3) px_at(100, 200);
    check("fade_f17", dut_rgb, 24'hFF0000);

    game_state = 3'd2;
    px_at(0, 0);
    repeat (3) px_at(100, 200);
    check("fade_win1", dut_rgb, 24'hC3C1B4);

    game_state = 3'd0;
    px_at(0, 0);
    repeat (3) px_at(100, 200);
    check("fade_clear", dut_rgb, 24'hC0C0C0);

    // Asynchronous reset mid-line with a commit pending.
    cfg_commit = 1'b1;
    px_at(300, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", dut_vec, RESET_VEC);
    check("async_busy", cfg_busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    px_at(0, 0);
    px_at(150, 305);
    px_at(420, 120);
    px_at(157, 309);
    px_at(500, 200);
    px_at(500, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
